// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front end for the ArithmeticLogicUnit.
// Takes one command per valid/ready handshake, drives one-hot ALU controls,
// sequences multi-cycle shifts, and holds a registered result until taken.
module alu_op_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [DATA_WIDTH-1:0]  cmd_a,
  input  logic [DATA_WIDTH-1:0]  cmd_b,
  input  logic [SHAMT_WIDTH-1:0] cmd_shamt,
  output logic                   alu_add,
  output logic                   alu_sub,
  output logic                   alu_lsr,
  output logic                   alu_lsh,
  output logic                   alu_rsh,
  output logic                   alu_and,
  output logic                   alu_or,
  output logic                   alu_xor,
  output logic                   alu_inv,
  output logic                   alu_clr,
  output logic [DATA_WIDTH-1:0]  alu_in1,
  output logic [DATA_WIDTH-1:0]  alu_in2,
  input  logic [DATA_WIDTH-1:0]  alu_out,
  input  logic                   alu_overflow,
  input  logic [3:0]             alu_shift_out,
  input  logic                   alu_shift_flag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic                   res_overflow,
  output logic                   res_shift_flag,
  output logic                   res_illegal
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EXEC  = 3'd1;
  localparam logic [2:0] S_SLOAD = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_SCAP  = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_INV = 4'd5;
  localparam logic [3:0] OP_CLR = 4'd6;
  localparam logic [3:0] OP_LSH = 4'd7;
  localparam logic [3:0] OP_RSH = 4'd8;

  logic [2:0]             state_q, state_d;
  logic [3:0]             op_q;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  in1_q, in2_q;
  logic                   ready_q, ready_d;
  logic                   res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0]  res_data_q, res_data_d;
  logic                   res_ovf_q, res_ovf_d;
  logic                   res_sflag_q, res_sflag_d;
  logic                   res_ill_q, res_ill_d;
  logic                   accept;

  // ready is only ever high in IDLE, so it alone qualifies an accept
  assign accept = cmd_valid && ready_q;

  // Next-state, shift counter and result capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_sflag_d = res_sflag_q;
    res_ill_d   = res_ill_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = cmd_shamt;
          if (cmd_op <= OP_CLR) begin
            state_d = S_EXEC;
          end else if (cmd_op == OP_LSH || cmd_op == OP_RSH) begin
            state_d = S_SLOAD;
          end else begin
            // Undefined opcode: answer immediately with a zeroed result
            state_d     = S_RESP;
            res_valid_d = 1'b1;
            res_data_d  = '0;
            res_ovf_d   = 1'b0;
            res_sflag_d = 1'b0;
            res_ill_d   = 1'b1;
          end
        end
      end
      S_EXEC: begin
        state_d     = S_RESP;
        res_valid_d = 1'b1;
        res_data_d  = alu_out;
        res_ovf_d   = (op_q == OP_ADD || op_q == OP_SUB) && alu_overflow;
        res_sflag_d = 1'b0;
        res_ill_d   = 1'b0;
      end
      S_SLOAD: begin
        state_d = (cnt_q == '0) ? S_SCAP : S_SHIFT;
      end
      S_SHIFT: begin
        // Entered with cnt_q >= 1; one ALU shift per cycle spent here
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          state_d = S_SCAP;
        end
      end
      S_SCAP: begin
        state_d     = S_RESP;
        res_valid_d = 1'b1;
        res_data_d  = {{(DATA_WIDTH-4){1'b0}}, alu_shift_out};
        res_ovf_d   = 1'b0;
        res_sflag_d = alu_shift_flag;
        res_ill_d   = 1'b0;
      end
      S_RESP: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State, operand latch and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_sflag_q <= 1'b0;
      res_ill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_sflag_q <= res_sflag_d;
      res_ill_q   <= res_ill_d;
      if (accept) begin
        op_q  <= cmd_op;
        in1_q <= cmd_a;
        in2_q <= cmd_b;
      end
    end
  end

  // One-hot ALU control decode from the registered state and opcode
  always_comb begin
    alu_add = 1'b0;
    alu_sub = 1'b0;
    alu_lsr = 1'b0;
    alu_lsh = 1'b0;
    alu_rsh = 1'b0;
    alu_and = 1'b0;
    alu_or  = 1'b0;
    alu_xor = 1'b0;
    alu_inv = 1'b0;
    alu_clr = 1'b0;
    case (state_q)
      S_EXEC: begin
        case (op_q)
          OP_ADD:  alu_add = 1'b1;
          OP_SUB:  alu_sub = 1'b1;
          OP_AND:  alu_and = 1'b1;
          OP_OR:   alu_or  = 1'b1;
          OP_XOR:  alu_xor = 1'b1;
          OP_INV:  alu_inv = 1'b1;
          OP_CLR:  alu_clr = 1'b1;
          default: ;
        endcase
      end
      S_SLOAD: alu_lsr = 1'b1;
      S_SHIFT: begin
        alu_lsh = (op_q == OP_LSH);
        alu_rsh = (op_q != OP_LSH);
      end
      default: ;
    endcase
  end

  assign cmd_ready      = ready_q;
  assign alu_in1        = in1_q;
  assign alu_in2        = in2_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_overflow   = res_ovf_q;
  assign res_shift_flag = res_sflag_q;
  assign res_illegal    = res_ill_q;

endmodule
